// File: rtl/pll_mod_ctrl.sv
// pll_mod_ctrl: initiator for the GW5A PLLA dynamic-reconfiguration (MD) port.
// Turns single register read/write requests into ADDR/OP/TAIL MD bus
// sequences and can pulse PLL reset and wait for lock after a write.
// Optional read-modify-write writes are enabled by defining PLL_MOD_RMW_EN.
module pll_mod_ctrl #(
  parameter int MDCLK_DIV    = 2,
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_relock,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [7:0] req_mask,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic       pll_mdclk,
  output logic [1:0] pll_mdopc,
  output logic       pll_mdainc,
  output logic [7:0] pll_mdwdi,
  input  logic [7:0] pll_mdrdo,
  output logic       pll_reset,
  input  logic       pll_lock
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_OP, S_TAIL, S_PLLRST, S_LOCKWAIT, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic        mdclk_q, mdclk_nx;
  logic [1:0]  opc_q, opc_nx;
  logic [7:0]  wdi_q, wdi_nx;
  logic        pllrst_q, pllrst_nx;
  logic        rsp_valid_q, rsp_valid_nx;
  logic [7:0]  rdata_q, rdata_nx;
  logic        err_q, err_nx;
  logic [7:0]  cap_q, cap_nx;
  logic        ready_q, busy_q;
  logic        wr_q, relock_q;
  logic [7:0]  addr_q, wdata_q;
  logic        lock_s1, lock_s2;
  logic        accept, phase_end, rise, fall;
  logic        rd_phase, returns_rd;
  logic [7:0]  wr_val;

`ifdef PLL_MOD_RMW_EN
  logic [7:0]  mask_q;
  logic        rmw_q, second_q, second_nx;

  // RMW runs a read pass then a write pass; the write pass merges the capture.
  assign rd_phase   = !wr_q || (rmw_q && !second_q);
  assign returns_rd = !wr_q || rmw_q;
  assign wr_val     = rmw_q ? ((cap_q & ~mask_q) | (wdata_q & mask_q)) : wdata_q;
`else
  logic        mask_unused;

  assign mask_unused = ^req_mask;
  assign rd_phase    = !wr_q;
  assign returns_rd  = !wr_q;
  assign wr_val      = wdata_q;
`endif

  assign accept    = req_valid && ready_q;
  assign phase_end = (cnt == 32'(MDCLK_DIV - 1));
  assign rise      = phase_end && !mdclk_q;
  assign fall      = phase_end && mdclk_q;

  // Next-state, MD bus and response values; bus fields only move on mdclk falls.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    mdclk_nx     = mdclk_q;
    opc_nx       = opc_q;
    wdi_nx       = wdi_q;
    pllrst_nx    = pllrst_q;
    rsp_valid_nx = 1'b0;
    rdata_nx     = rdata_q;
    err_nx       = err_q;
    cap_nx       = cap_q;
`ifdef PLL_MOD_RMW_EN
    second_nx    = second_q;
`endif
    if (state == S_ADDR || state == S_OP || state == S_TAIL) begin
      cnt_nx   = phase_end ? '0 : cnt + 32'd1;
      mdclk_nx = phase_end ? ~mdclk_q : mdclk_q;
    end
    case (state)
      S_IDLE: begin
        cnt_nx   = '0;
        mdclk_nx = 1'b0;
        opc_nx   = 2'b00;
        if (accept) begin
          state_nx = S_ADDR;
          opc_nx   = 2'b11;
          wdi_nx   = req_addr;
`ifdef PLL_MOD_RMW_EN
          second_nx = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        if (fall) begin
          state_nx = S_OP;
          if (rd_phase) begin
            opc_nx = 2'b10;
            wdi_nx = '0;
          end else begin
            opc_nx = 2'b01;
            wdi_nx = wr_val;
          end
        end
      end
      S_OP: begin
        if (fall) begin
          state_nx = S_TAIL;
          opc_nx   = 2'b00;
          wdi_nx   = '0;
        end
      end
      S_TAIL: begin
        if (rise && rd_phase) cap_nx = pll_mdrdo;
        if (fall) begin
`ifdef PLL_MOD_RMW_EN
          if (rmw_q && !second_q) begin
            state_nx  = S_ADDR;
            second_nx = 1'b1;
            opc_nx    = 2'b11;
            wdi_nx    = addr_q;
          end else
`endif
          if (wr_q && relock_q) begin
            state_nx  = S_PLLRST;
            pllrst_nx = 1'b1;
            cnt_nx    = '0;
          end else begin
            state_nx     = S_DONE;
            rsp_valid_nx = 1'b1;
            err_nx       = 1'b0;
            if (returns_rd) rdata_nx = cap_q;
          end
        end
      end
      S_PLLRST: begin
        if (cnt == 32'(RESET_CYCLES - 1)) begin
          state_nx  = S_LOCKWAIT;
          pllrst_nx = 1'b0;
          cnt_nx    = '0;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      S_LOCKWAIT: begin
        if ((cnt >= 32'd4) && lock_s2) begin
          state_nx     = S_DONE;
          rsp_valid_nx = 1'b1;
          err_nx       = 1'b0;
          if (returns_rd) rdata_nx = cap_q;
        end else if (cnt >= 32'(LOCK_TIMEOUT)) begin
          state_nx     = S_DONE;
          rsp_valid_nx = 1'b1;
          err_nx       = 1'b1;
          if (returns_rd) rdata_nx = cap_q;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        opc_nx   = 2'b00;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transfer without a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mdclk_q     <= 1'b0;
      opc_q       <= 2'b00;
      wdi_q       <= '0;
      pllrst_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cap_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PLL_MOD_RMW_EN
      second_q    <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      mdclk_q     <= mdclk_nx;
      opc_q       <= opc_nx;
      wdi_q       <= wdi_nx;
      pllrst_q    <= pllrst_nx;
      rsp_valid_q <= rsp_valid_nx;
      rdata_q     <= rdata_nx;
      err_q       <= err_nx;
      cap_q       <= cap_nx;
      ready_q     <= (state_nx == S_IDLE);
      busy_q      <= (state_nx != S_IDLE);
`ifdef PLL_MOD_RMW_EN
      second_q    <= second_nx;
`endif
    end
  end

  // Request fields are captured on accept and held for the whole transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      relock_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef PLL_MOD_RMW_EN
      mask_q   <= '0;
      rmw_q    <= 1'b0;
`endif
    end else if (accept) begin
      wr_q     <= req_write;
      relock_q <= req_relock;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
`ifdef PLL_MOD_RMW_EN
      mask_q   <= req_mask;
      rmw_q    <= req_write && (req_mask != 8'hFF);
`endif
    end
  end

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      lock_s1 <= pll_lock;
      lock_s2 <= lock_s1;
    end
  end

  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign pll_mdclk  = mdclk_q;
  assign pll_mdopc  = opc_q;
  assign pll_mdainc = 1'b0;
  assign pll_mdwdi  = wdi_q;
  assign pll_reset  = pllrst_q;

endmodule

// File: doc/pll_mod_ctrl.md
Name: pll_mod_ctrl

Overview:
- Initiator side of the GW5A PLLA dynamic-reconfiguration (MD) port.
- Drives mdclk, mdopc, mdainc and mdwdi into the PLL wrapper, and captures mdrdo from it.
- Converts single register read/write requests from board control logic into MD bus sequences. One use is retuning pixel-clock output dividers for NTSC/PAL switching.
- After a write it can optionally pulse PLL reset and wait for lock.

Parameters:
- MDCLK_DIV, 2: clk cycles per mdclk half-period (>=1). One MD cycle = 2*MDCLK_DIV clk.
- RESET_CYCLES, 16: clk cycles pll_reset is held high during relock.
- LOCK_TIMEOUT, 65535: clk cycles to wait for lock before flagging error.

Ports:
- clk  in  1  system clock; also the source of pll_mdclk.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_relock  in  1  write only: pulse PLL reset and await lock afterwards.
- req_addr  in  8  MD register address.
- req_wdata  in  8  write data.
- req_mask  in  8  RMW bit mask (PLL_MOD_RMW_EN only; ignored otherwise).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read data, valid with rsp_valid.
- rsp_err  out  1  lock timeout, valid with rsp_valid.
- busy  out  1  not IDLE.
- pll_mdclk  out  1  MD clock to the PLL.
- pll_mdopc  out  2  00 NOP, 01 write, 10 read, 11 address load.
- pll_mdainc  out  1  tied 0 (single-register accesses only).
- pll_mdwdi  out  8  address or write data.
- pll_mdrdo  in  8  PLL read data.
- pll_reset  out  1  PLL reset.
- pll_lock  in  1  PLL lock, asynchronous; 2-FF synchronised internally.

Behaviour:
- Reset values:
  - req_ready=0 while rst_n low, 1 in the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - pll_mdclk=0, pll_mdopc=00, pll_mdwdi=0, pll_reset=0.
  - Lock synchroniser cleared.
  - Reset mid-operation aborts immediately, with no response.
- mdclk generation:
  - A phase counter runs only while busy and toggles pll_mdclk every MDCLK_DIV clk.
  - mdopc/mdwdi change only in the clk cycle where mdclk falls, so they are stable across each rising edge.
  - pll_mdclk idles low in IDLE.
- Handshake:
  - Accept when req_valid && req_ready; latch all request fields.
  - req_ready drops the next cycle.
  - Requests presented while busy are held off, not dropped.
- States:
  - IDLE → ADDR (opc=11, wdi=addr) → OP.
  - OP is opc=01 with wdi=wdata, or opc=10 for a read.
  - OP → TAIL (opc=00).
  - On a read, rsp_rdata is captured from pll_mdrdo at the TAIL rising edge.
  - TAIL → DONE, or → PLLRST if write && relock.
  - Each of ADDR, OP and TAIL lasts exactly one MD cycle.
  - PLLRST: pll_reset=1 for RESET_CYCLES clk, mdclk parked low → LOCKWAIT.
  - LOCKWAIT: pll_reset=0; synced lock is ignored for the first 4 clk.
    - Lock high → DONE, err=0.
    - Counter reaches LOCK_TIMEOUT → DONE, err=1.
  - DONE: rsp_valid=1 for one clk, opc=00 → IDLE.
- Latency:
  - Plain read or write: rsp_valid is exactly 6*MDCLK_DIV+1 clk after the accept cycle.
  - Relock adds RESET_CYCLES + LOCKWAIT duration.
- Response hold:
  - rsp_rdata holds its value until the next read completes.
  - Writes leave rsp_rdata unchanged.
  - rsp_err is updated on every response; it is 0 for reads and non-relock writes.
- Boundary: req_relock on a read is ignored.

Optional Feature:
- Macro: PLL_MOD_RMW_EN.
- When defined, a write with req_mask != 8'hFF does read-modify-write:
  - ADDR, RD, TAIL with capture, then ADDR, WR, TAIL.
  - Data written = (captured & ~mask) | (wdata & mask).
  - Latency is 12*MDCLK_DIV+1 clk before any relock.
  - rsp_rdata returns the pre-modify value.
  - mask=8'hFF takes the plain write path.
- When undefined: req_mask is unused, every write is a plain write, and no RMW states or registers are synthesised.

Test Plan:
1. Write (MDCLK_DIV=2), addr 8'h12, data 8'h32, relock=0.
   - MD bus sequence on mdclk rising edges is (11,12), (01,32), (00,x).
   - rsp_valid at clk 13, err=0.
2. Read, addr 8'h12; PLL model returns 8'h32 during TAIL.
   - rsp_rdata=8'h32, rsp_valid at clk 13.
3. Write with relock; model raises lock 50 clk after reset falls.
   - pll_reset high exactly 16 clk.
   - rsp_valid with err=0.
   - req_ready stays low throughout.
4. Relock with lock held low, LOCK_TIMEOUT=100.
   - rsp_valid with err=1, about 100 clk after reset release.
5. rst_n low during the OP state of a write.
   - Next clk: opc=00, mdclk=0, busy=0, and no rsp_valid.
   - A new request is accepted normally afterwards.
6. PLL_MOD_RMW_EN: register holds 8'hA5; write wdata 8'h0F, mask 8'h0F.
   - Value written = 8'hAF.
   - rsp_rdata=8'hA5, latency 25 clk.
